dot_prod_feeder: RTL and testbench
==================================

# dot_prod_feeder

Host-side sequencer that drives the dot-product datapath from the far end of its element-stream interface. Software loads element pairs into an internal buffer through a simple write port, sets the length and pulses `go`. The block then issues a start pulse, streams the pairs one per accepted cycle, waits for the accelerator's completion flag and latches the result for readback. It sits between the AXI register/buffer front end and the `dot_prod` core.

## Interface
- `DEPTH`, 64: buffer entries (element pairs); power of two, ≥2.
- `TIMEOUT`, 1024: cycles allowed in WAIT before abort (used only with `FEEDER_TIMEOUT_EN`).
- `clk`  in  1  clock; all logic on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `wr_en`  in  1  buffer write strobe.
- `wr_addr`  in  $clog2(DEPTH)  buffer write index.
- `wr_data`  in  16  [7:0] = A element, [15:8] = B element (signed 8-bit each).
- `vector_len`  in  32  number of pairs N; sampled when `go` is accepted.
- `go`  in  1  single-cycle start request.
- `acc_ready`  in  1  accelerator can take an element this cycle.
- `acc_done`  in  1  accelerator completion flag.
- `acc_result`  in  32  signed accelerator result.
- `acc_start`  out  1  one-cycle start pulse to accelerator.
- `vector_valid`  out  1  element pair valid.
- `vector_a_out`  out  8  signed A element.
- `vector_b_out`  out  8  signed B element.
- `busy`  out  1  high in any state except IDLE.
- `result`  out  32  latched signed result.
- `result_valid`  out  1  sticky; result available.
- `err`  out  1  sticky; bad length or timeout.

## Operation
- States: IDLE, START, STREAM, WAIT.
- IDLE: `wr_en` writes `wr_data` into `buf[wr_addr]`.
  - `go` with 1 ≤ `vector_len` ≤ DEPTH: latch N, clear index, clear `result_valid` and `err`, go to START.
  - `go` with `vector_len` = 0 or > DEPTH: set `err`, clear `result_valid`, stay in IDLE.
- START: `acc_start` = 1 for exactly this cycle. Load `buf[0]` into the output registers. Next state is STREAM.
- STREAM: `vector_valid` = 1.
  - A transfer occurs when `vector_valid && acc_ready`.
  - On a transfer with index < N−1: increment index and load `buf[index+1]`.
  - On the transfer with index = N−1: go to WAIT and drop `vector_valid`.
  - While `acc_ready` = 0, hold outputs and index unchanged.
- WAIT: on `acc_done` = 1, `result` ← `acc_result`, set `result_valid`, go to IDLE.
- `wr_en` outside IDLE is ignored; the buffer is never modified while busy.
- `go` outside IDLE is ignored.
- `acc_done` outside WAIT is ignored.
- Index counter width is $clog2(DEPTH); it never wraps because N ≤ DEPTH.
- The N compare uses the full 32 bits of the latched length.

## Timing
- Reset: state IDLE; index 0; every output 0 (`acc_start`, `vector_valid`, `vector_a_out`, `vector_b_out`, `busy`, `result`, `result_valid`, `err`). Buffer contents are not reset.
- Reset asserted mid-operation aborts immediately to IDLE with the above values.
- Latency with `go` accepted at cycle t:
  - `acc_start` and `busy` high at t+1.
  - First valid element at t+2.
  - With `acc_ready` held at 1, the last element is at t+1+N.
  - WAIT is entered at t+2+N.
- `result`/`result_valid` update in the cycle after `acc_done` is sampled in WAIT. `busy` falls in that same cycle.
- Write then `go` in consecutive cycles: the write is visible to the stream.
- `go` and `wr_en` in the same cycle in IDLE: both take effect, and the write lands before START reads it.

## Configuration
- `FEEDER_TIMEOUT_EN` defined:
  - A counter runs in WAIT.
  - If `acc_done` has not arrived after TIMEOUT cycles: set `err`, leave `result_valid` = 0, return to IDLE.
  - `acc_done` arriving on the terminal count cycle wins and is a normal completion.
- Macro undefined: WAIT persists until `acc_done` or reset; no counter logic is present.

## Test plan
- Load A={1,2,3,4}, B={5,6,7,8}; N=4; `acc_ready`=1; model returns 70 → `acc_start` one cycle, 4 consecutive valid cycles in order, `result`=70, `result_valid`=1, `busy` low after done.
- Same stream with `acc_ready` toggling 1,0,0,1,… → each pair presented until accepted, none skipped or duplicated, exactly 4 transfers.
- `go` with N=0, then N=DEPTH+1 → `err`=1, `busy` stays 0, no `acc_start`. A following valid `go` clears `err`.
- N=DEPTH with signed extremes (−128×−128 in every pair) → DEPTH transfers, index ends at DEPTH−1, `result` equals the model's 32-bit value.
- `wr_en` and a second `go` during STREAM, then `reset` pulsed during WAIT → buffer unchanged, second `go` ignored, all outputs 0 after reset.
- With `FEEDER_TIMEOUT_EN`, withhold `acc_done` → `err`=1 exactly TIMEOUT cycles after WAIT entry, `result_valid`=0, state IDLE.

Source files
------------

// File: rtl/dot_prod_feeder.sv
// Host-side sequencer: buffers element pairs, then streams them to the dot_prod core and latches its result.
// Optional WAIT-state watchdog is compiled in with `define FEEDER_TIMEOUT_EN.
module dot_prod_feeder #(
    parameter int DEPTH   = 64,
    parameter int TIMEOUT = 1024
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [15:0]              wr_data,
    input  logic [31:0]              vector_len,
    input  logic                     go,
    input  logic                     acc_ready,
    input  logic                     acc_done,
    input  logic signed [31:0]       acc_result,
    output logic                     acc_start,
    output logic                     vector_valid,
    output logic signed [7:0]        vector_a_out,
    output logic signed [7:0]        vector_b_out,
    output logic                     busy,
    output logic signed [31:0]       result,
    output logic                     result_valid,
    output logic                     err
);

    localparam int IW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, START, STREAM, WAIT} state_t;

    state_t        state, state_next;
    logic [15:0]   pair_buf [DEPTH];
    logic [IW-1:0] idx;
    logic [31:0]   n_len;
    logic          len_ok;
    logic          go_ok, go_bad, transfer, last_xfer, done_hit, timeout_hit;

`ifdef FEEDER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] wait_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            wait_cnt <= '0;
        else if (state != WAIT)
            wait_cnt <= '0;
        else
            wait_cnt <= wait_cnt + 1'b1;
    end
`endif

    assign len_ok = (vector_len != 32'd0) && (vector_len <= 32'(DEPTH));

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next   = state;
        acc_start    = 1'b0;
        vector_valid = 1'b0;
        busy         = 1'b1;
        go_ok        = 1'b0;
        go_bad       = 1'b0;
        transfer     = 1'b0;
        last_xfer    = 1'b0;
        done_hit     = 1'b0;
        timeout_hit  = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (go) begin
                    if (len_ok) begin
                        go_ok      = 1'b1;
                        state_next = START;
                    end else begin
                        go_bad = 1'b1;
                    end
                end
            end
            START: begin
                acc_start  = 1'b1;
                state_next = STREAM;
            end
            STREAM: begin
                vector_valid = 1'b1;
                transfer     = acc_ready;
                last_xfer    = acc_ready && (32'(idx) == n_len - 32'd1);
                if (last_xfer)
                    state_next = WAIT;
            end
            WAIT: begin
                if (acc_done) begin
                    done_hit   = 1'b1;
                    state_next = IDLE;
                end
`ifdef FEEDER_TIMEOUT_EN
                // A done on the terminal count cycle takes priority over the timeout.
                else if (wait_cnt == TW'(TIMEOUT - 1)) begin
                    timeout_hit = 1'b1;
                    state_next  = IDLE;
                end
`endif
            end
            default: state_next = IDLE;
        endcase
    end

    // Buffer is only writable in IDLE so a running stream never sees it change.
    always_ff @(posedge clk) begin
        if (wr_en && (state == IDLE))
            pair_buf[wr_addr] <= wr_data;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx          <= '0;
            n_len        <= '0;
            vector_a_out <= '0;
            vector_b_out <= '0;
            result       <= '0;
            result_valid <= 1'b0;
            err          <= 1'b0;
        end else begin
            if (go_ok) begin
                n_len        <= vector_len;
                idx          <= '0;
                result_valid <= 1'b0;
                err          <= 1'b0;
            end
            if (go_bad) begin
                err          <= 1'b1;
                result_valid <= 1'b0;
            end
            if (state == START)
                {vector_b_out, vector_a_out} <= pair_buf[0];
            if (transfer && !last_xfer) begin
                idx                          <= idx + 1'b1;
                {vector_b_out, vector_a_out} <= pair_buf[idx + 1'b1];
            end
            if (done_hit) begin
                result       <= acc_result;
                result_valid <= 1'b1;
            end
            if (timeout_hit)
                err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_dot_prod_feeder.sv
// Directed self-checking bench for dot_prod_feeder; the bench plays the accelerator and keeps its own buffer model.
// Timeout scenario is included when FEEDER_TIMEOUT_EN is defined.
module tb_dot_prod_feeder;

    localparam int DEPTH   = 64;
    localparam int TIMEOUT = 1024;
    localparam int AW      = $clog2(DEPTH);

    logic                 clk = 1'b0;
    logic                 reset = 1'b1;
    logic                 wr_en = 1'b0;
    logic [AW-1:0]        wr_addr = '0;
    logic [15:0]          wr_data = '0;
    logic [31:0]          vector_len = '0;
    logic                 go = 1'b0;
    logic                 acc_ready = 1'b0;
    logic                 acc_done = 1'b0;
    logic signed [31:0]   acc_result = '0;
    logic                 acc_start;
    logic                 vector_valid;
    logic signed [7:0]    vector_a_out;
    logic signed [7:0]    vector_b_out;
    logic                 busy;
    logic signed [31:0]   result;
    logic                 result_valid;
    logic                 err;

    int tests_run    = 0;
    int tests_failed = 0;

    logic signed [7:0] ex_a [DEPTH];
    logic signed [7:0] ex_b [DEPTH];

    dot_prod_feeder #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .vector_len(vector_len), .go(go), .acc_ready(acc_ready), .acc_done(acc_done),
        .acc_result(acc_result), .acc_start(acc_start), .vector_valid(vector_valid),
        .vector_a_out(vector_a_out), .vector_b_out(vector_b_out), .busy(busy),
        .result(result), .result_valid(result_valid), .err(err)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests_run++;
        assert (observed === expected) else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed %0d (0x%h), expected %0d (0x%h)",
                   tag, $signed(observed), observed, $signed(expected), expected);
        end
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_acc_start"},    32'(acc_start),    32'd0);
        checkOutput({tag, "_vector_valid"}, 32'(vector_valid), 32'd0);
        checkOutput({tag, "_vector_a"},     32'(vector_a_out), 32'd0);
        checkOutput({tag, "_vector_b"},     32'(vector_b_out), 32'd0);
        checkOutput({tag, "_busy"},         32'(busy),         32'd0);
        checkOutput({tag, "_result"},       32'(result),       32'd0);
        checkOutput({tag, "_result_valid"}, 32'(result_valid), 32'd0);
        checkOutput({tag, "_err"},          32'(err),          32'd0);
    endtask

    // Drives one cycle of inputs (from a falling edge to the next) and mirrors IDLE writes into the model.
    task automatic applyStimulus(input logic we, input logic [AW-1:0] wa, input logic [15:0] wd,
                                 input logic g, input logic [31:0] len);
        wr_en      = we;
        wr_addr    = wa;
        wr_data    = wd;
        go         = g;
        vector_len = len;
        if (we) begin
            ex_a[wa] = wd[7:0];
            ex_b[wa] = wd[15:8];
        end
        @(negedge clk);
        wr_en = 1'b0;
        go    = 1'b0;
    endtask

    // Entered at the falling edge of the START cycle; streams n pairs and either completes or resets in WAIT.
    task automatic runStream(input int n, input bit toggle, input bit use_reset);
        int cyc;
        int xfer;
        int starts;
        int model;
        model = 0;
        for (int i = 0; i < n; i++)
            model += int'(ex_a[i]) * int'(ex_b[i]);

        checkOutput("start_pulse",       32'(acc_start),    32'd1);
        checkOutput("start_busy",        32'(busy),         32'd1);
        checkOutput("start_valid_low",   32'(vector_valid), 32'd0);
        checkOutput("start_rv_cleared",  32'(result_valid), 32'd0);
        checkOutput("start_err_cleared", 32'(err),          32'd0);
        @(negedge clk);

        cyc = 0;
        xfer = 0;
        starts = 0;
        while (xfer < n && cyc < 4 * n + 16) begin
            acc_ready = !toggle || (cyc % 3 == 0);
            if (acc_start) starts++;
            checkOutput("stream_valid", 32'(vector_valid), 32'd1);
            checkOutput("stream_a", 32'(vector_a_out), 32'(ex_a[xfer]));
            checkOutput("stream_b", 32'(vector_b_out), 32'(ex_b[xfer]));
            if (vector_valid && acc_ready) xfer++;
            @(negedge clk);
            cyc++;
        end
        acc_ready = 1'b0;

        checkOutput("xfer_count",     32'(xfer),   32'(n));
        checkOutput("stream_cycles",  32'(cyc),    toggle ? 32'(3 * (n - 1) + 1) : 32'(n));
        checkOutput("no_restart",     32'(starts), 32'd0);
        checkOutput("wait_valid_low", 32'(vector_valid), 32'd0);
        checkOutput("wait_busy",      32'(busy),   32'd1);
        repeat (2) @(negedge clk);
        checkOutput("wait_holds_busy", 32'(busy),         32'd1);
        checkOutput("wait_no_result",  32'(result_valid), 32'd0);

        if (use_reset) begin
            reset = 1'b1;
            wr_en = 1'b0;
            go    = 1'b0;
            @(negedge clk);
            checkAllZero("mid_reset");
            reset = 1'b0;
            @(negedge clk);
            checkAllZero("post_reset");
        end else begin
            acc_result = model;
            acc_done   = 1'b1;
            @(negedge clk);
            acc_done   = 1'b0;
            acc_result = '0;
            checkOutput("result",        32'(result),       32'(model));
            checkOutput("result_valid",  32'(result_valid), 32'd1);
            checkOutput("done_busy_low", 32'(busy),         32'd0);
            checkOutput("done_err",      32'(err),          32'd0);
            @(negedge clk);
            checkOutput("rv_sticky",     32'(result_valid), 32'd1);
        end
    endtask

    initial begin
        repeat (2) @(negedge clk);
        checkAllZero("reset");
        reset = 1'b0;
        @(negedge clk);
        checkAllZero("after_release");

        // A = {1,2,3,4}, B = {5,6,7,8}: dot product 70
        for (int i = 0; i < 4; i++)
            applyStimulus(1'b1, AW'(i), {8'(5 + i), 8'(1 + i)}, 1'b0, 32'd0);
        applyStimulus(1'b0, '0, 16'h0000, 1'b1, 32'd4);
        runStream(4, 1'b0, 1'b0);

        // Same stream with acc_ready pattern 1,0,0,1,...
        applyStimulus(1'b0, '0, 16'h0000, 1'b1, 32'd4);
        runStream(4, 1'b1, 1'b0);

        // Illegal lengths are rejected without starting
        applyStimulus(1'b0, '0, 16'h0000, 1'b1, 32'd0);
        checkOutput("len0_err",   32'(err),          32'd1);
        checkOutput("len0_busy",  32'(busy),         32'd0);
        checkOutput("len0_start", 32'(acc_start),    32'd0);
        checkOutput("len0_rv",    32'(result_valid), 32'd0);
        @(negedge clk);
        checkOutput("len0_busy_later",  32'(busy),      32'd0);
        checkOutput("len0_start_later", 32'(acc_start), 32'd0);
        applyStimulus(1'b0, '0, 16'h0000, 1'b1, 32'(DEPTH + 1));
        checkOutput("lenbig_err",   32'(err),       32'd1);
        checkOutput("lenbig_busy",  32'(busy),      32'd0);
        checkOutput("lenbig_start", 32'(acc_start), 32'd0);
        applyStimulus(1'b0, '0, 16'h0000, 1'b1, 32'h8000_0002);
        checkOutput("lenhigh_err",  32'(err),       32'd1);
        checkOutput("lenhigh_busy", 32'(busy),      32'd0);

        // Write then go next cycle (addr 1), and write together with go (addr 0); clears err
        applyStimulus(1'b1, AW'(1), 16'h9C7F, 1'b0, 32'd0);
        applyStimulus(1'b1, AW'(0), 16'h0280, 1'b1, 32'd2);
        runStream(2, 1'b0, 1'b0);

        // Full-depth stream of signed extremes
        for (int i = 0; i < DEPTH; i++)
            applyStimulus(1'b1, AW'(i), 16'h8080, 1'b0, 32'd0);
        applyStimulus(1'b0, '0, 16'h0000, 1'b1, 32'(DEPTH));
        runStream(DEPTH, 1'b0, 1'b0);

        // Writes and a second go during the stream are ignored; reset in WAIT aborts
        applyStimulus(1'b1, AW'(0), 16'hF00A, 1'b0, 32'd0);
        applyStimulus(1'b1, AW'(1), 16'h0BFE, 1'b0, 32'd0);
        applyStimulus(1'b1, AW'(2), 16'h7F81, 1'b0, 32'd0);
        applyStimulus(1'b1, AW'(3), 16'h8001, 1'b0, 32'd0);
        applyStimulus(1'b0, '0, 16'h0000, 1'b1, 32'd4);
        wr_en      = 1'b1;
        wr_addr    = AW'(1);
        wr_data    = 16'hFFFF;
        go         = 1'b1;
        vector_len = 32'd2;
        runStream(4, 1'b1, 1'b1);
        applyStimulus(1'b0, '0, 16'h0000, 1'b1, 32'd4);
        runStream(4, 1'b0, 1'b0);

`ifdef FEEDER_TIMEOUT_EN
        begin
            int k;
            applyStimulus(1'b0, '0, 16'h0000, 1'b1, 32'd2);
            acc_ready = 1'b1;
            repeat (3) @(negedge clk);
            acc_ready = 1'b0;
            checkOutput("to_wait_busy",  32'(busy),         32'd1);
            checkOutput("to_wait_valid", 32'(vector_valid), 32'd0);
            k = 0;
            while (!err && k < TIMEOUT + 8) begin
                @(negedge clk);
                k++;
            end
            checkOutput("to_cycles", 32'(k),            32'(TIMEOUT));
            checkOutput("to_err",    32'(err),          32'd1);
            checkOutput("to_rv",     32'(result_valid), 32'd0);
            checkOutput("to_busy",   32'(busy),         32'd0);
        end
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
